// File: rtl/nibble_serial_add_ctrl.sv
// Wide add/subtract sequenced through one 4-bit ripple slice,
// one nibble per clock, least significant nibble first.
module nibble_add4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  logic [4:0] w_c;

  assign w_c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign S[i]     = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign Cout = w_c[4];

endmodule

module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  // busy and done are the state bits themselves
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]    r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_work;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;

  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic [3:0]    w_s;
  logic          w_co;
  logic          w_last;
  logic [W-1:0]  w_work_nx;
  logic          w_ovf;

  assign w_a_nib = r_a[4*r_idx +: 4];
  assign w_b_nib = r_b[4*r_idx +: 4];
  assign w_last  = (r_idx == IW'(NIBBLES - 1));

  nibble_add4 u_slice (
    .A    (w_a_nib),
    .B    (w_b_nib),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_co)
  );

  always_comb begin
    w_work_nx = r_work;
    w_work_nx[4*r_idx +: 4] = w_s;
  end

  assign w_ovf = (r_a[W-1] == r_b[W-1]) &&
                 (w_work_nx[W-1] != r_a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
            r_work  <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work  <= w_work_nx;
          r_carry <= w_co;
          if (w_last) begin
            r_idx   <= '0;
            r_sum   <= w_work_nx;
            r_cout  <= w_co;
            r_ovf   <= w_ovf;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_state[0];
  assign done     = r_state[1];
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: directed and random operations
// on a 4-nibble and a 1-nibble instance against an arithmetic model.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start4, sub4, busy4, done4, cout4, ovf4;
  logic [15:0] a4, b4, sum4;
  logic        start1, sub1, busy1, done1, cout1, ovf1;
  logic [3:0]  a1, b1, sum1;

  int n_chk;
  int n_fail;

  nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start4),
    .sub      (sub4),
    .a        (a4),
    .b        (b4),
    .busy     (busy4),
    .done     (done4),
    .sum      (sum4),
    .cout     (cout4),
    .overflow (ovf4)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .sub      (sub1),
    .a        (a1),
    .b        (b1),
    .busy     (busy1),
    .done     (done1),
    .sum      (sum1),
    .cout     (cout1),
    .overflow (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed/unsigned arithmetic view of the operation, modulo 2^w
  function automatic void ref_op(input int w,
                                 input longint a,
                                 input longint b,
                                 input bit s,
                                 output logic [63:0] rs,
                                 output bit rc,
                                 output bit rv);
    longint m, half, sa, sb, r;
    m    = longint'(1) << w;
    half = m / 2;
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    if (s) begin
      r  = sa - sb;
      rc = (a >= b);
      rs = (a - b) & (m - 1);
    end else begin
      r  = sa + sb;
      rc = ((a + b) >= m);
      rs = (a + b) & (m - 1);
    end
    rv = (r < -half) || (r >= half);
  endfunction

  task automatic op4(input logic [15:0] a, input logic [15:0] b,
                     input bit s, input bit inject);
    logic [63:0] es;
    bit ec, ev;
    int nb, nd, dat;
    logic [15:0] gs;
    logic gc, gv;
    ref_op(16, longint'(a), longint'(b), s, es, ec, ev);
    gs = 'x; gc = 1'bx; gv = 1'bx;
    @(negedge clk);
    a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = 16'($urandom); b4 = 16'($urandom); sub4 = 1'($urandom);
    nb = 0; nd = 0; dat = -1;
    for (int i = 0; i < 12; i++) begin
      if (inject && i == 2) begin
        a4 = 16'hAAAA; b4 = 16'h5555; sub4 = 1'b0; start4 = 1'b1;
      end
      if (inject && i == 3) start4 = 1'b0;
      if (busy4) nb++;
      if (done4) begin
        nd++;
        if (dat < 0) begin
          dat = i; gs = sum4; gc = cout4; gv = ovf4;
        end
      end
      @(posedge clk); #1;
    end
    chk("n4_busy_cycles", 64'(nb), 64'd4);
    chk("n4_done_pulses", 64'(nd), 64'd1);
    chk("n4_done_latency", 64'(dat), 64'd4);
    chk("n4_sum", 64'(gs), es);
    chk("n4_cout", 64'(gc), 64'(ec));
    chk("n4_ovf", 64'(gv), 64'(ev));
    chk("n4_sum_hold", 64'(sum4), es);
  endtask

  task automatic op1(input logic [3:0] a, input logic [3:0] b,
                     input bit s);
    logic [63:0] es;
    bit ec, ev;
    int nb, nd, dat;
    logic [3:0] gs;
    logic gc, gv;
    ref_op(4, longint'(a), longint'(b), s, es, ec, ev);
    gs = 'x; gc = 1'bx; gv = 1'bx;
    @(negedge clk);
    a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    a1 = 4'($urandom); b1 = 4'($urandom);
    nb = 0; nd = 0; dat = -1;
    for (int i = 0; i < 6; i++) begin
      if (busy1) nb++;
      if (done1) begin
        nd++;
        if (dat < 0) begin
          dat = i; gs = sum1; gc = cout1; gv = ovf1;
        end
      end
      @(posedge clk); #1;
    end
    chk("n1_busy_cycles", 64'(nb), 64'd1);
    chk("n1_done_pulses", 64'(nd), 64'd1);
    chk("n1_done_latency", 64'(dat), 64'd1);
    chk("n1_sum", 64'(gs), es);
    chk("n1_cout", 64'(gc), 64'(ec));
    chk("n1_ovf", 64'(gv), 64'(ev));
  endtask

  initial begin
    int nd, t0, t1;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy4", 64'(busy4), 64'd0);
    chk("rst_done4", 64'(done4), 64'd0);
    chk("rst_sum4", 64'(sum4), 64'd0);
    chk("rst_cout4", 64'(cout4), 64'd0);
    chk("rst_ovf4", 64'(ovf4), 64'd0);
    chk("rst_busy1", 64'(busy1), 64'd0);
    chk("rst_sum1", 64'(sum1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op4(16'h1234, 16'h4321, 1'b0, 1'b0);
    op4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op4(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op4(16'h0005, 16'h0007, 1'b1, 1'b0);
    op4(16'h8000, 16'h0001, 1'b1, 1'b0);
    op4(16'h0001, 16'h0001, 1'b0, 1'b1);

    // Abort in mid-RUN: outputs clear at once, no done afterwards
    @(negedge clk);
    a4 = 16'h1111; b4 = 16'h2222; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy4), 64'd0);
    chk("abort_sum", 64'(sum4), 64'd0);
    chk("abort_cout", 64'(cout4), 64'd0);
    chk("abort_ovf", 64'(ovf4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    op4(16'h0003, 16'h0004, 1'b0, 1'b0);

    // start held high relaunches every NIBBLES+2 cycles
    @(negedge clk);
    a4 = 16'h0102; b4 = 16'h0304; sub4 = 1'b0; start4 = 1'b1;
    t0 = -1; t1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done4) begin
        if (t0 < 0) t0 = i;
        else if (t1 < 0) t1 = i;
      end
    end
    start4 = 1'b0;
    chk("held_start_period", 64'(t1 - t0), 64'd6);
    chk("held_start_sum", 64'(sum4), 64'h0406);
    repeat (8) @(posedge clk);

    op1(4'b0110, 4'b1001, 1'b0);
    op1(4'b0101, 4'b0101, 1'b0);

    for (int k = 0; k < 25; k++)
      op4(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    op4(16'h0000, 16'h8000, 1'b1, 1'b0);
    op4(16'h1234, 16'h1234, 1'b1, 1'b0);
    for (int k = 0; k < 12; k++)
      op1(4'($urandom), 4'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
